// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral: DMA channel endpoint answering DREQ/DACK/IOR_N/IOW_N, with a byte FIFO
// between the DMA bus and a local valid/ready port.
module dma_io_peripheral #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 4,
    parameter int DEMAND = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    output logic                     DREQ,
    input  logic                     DACK,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic                     EOP_N,
    input  logic [7:0]               DB_IN,
    output logic [7:0]               DB_OUT,
    output logic                     DB_OE,
    input  logic                     cfg_en,
    input  logic                     cfg_dir,
    input  logic                     flush,
    input  logic                     lcl_wr_valid,
    output logic                     lcl_wr_ready,
    input  logic [7:0]               lcl_wr_data,
    output logic                     lcl_rd_valid,
    input  logic                     lcl_rd_ready,
    output logic [7:0]               lcl_rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     tc_seen,
    output logic                     err,
    input  logic                     clr_status
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t          r_state, w_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]      r_db, w_wdata;
    logic            r_dir, r_beat_lo, r_eop, r_dreq, r_tc, r_err;
    logic            w_strb, w_act, w_lo_smp, w_beat_end, w_empty, w_full;
    logic            w_push, w_pop, w_bus_push, w_bus_pop, w_cond, w_cond_post;
    logic            w_tc_set, w_err_set;

    assign w_empty     = r_cnt == '0;
    assign w_full      = r_cnt == CW'(DEPTH);
    assign w_strb      = r_dir ? IOW_N : IOR_N;
    assign w_act       = r_state == REQ || r_state == XFER;
    assign w_lo_smp    = ~w_strb & DACK & w_act;
    // A beat ends when the strobe is seen high after a low sample taken with DACK
    assign w_beat_end  = r_state == XFER && r_beat_lo && w_strb;
    assign w_bus_pop   = w_beat_end & ~r_dir & ~w_empty;
    assign w_bus_push  = w_beat_end & r_dir & ~w_full;
    assign lcl_wr_ready = ~r_dir & ~w_full;
    assign lcl_rd_valid = r_dir & ~w_empty;
    assign w_push      = r_dir ? w_bus_push : lcl_wr_valid & lcl_wr_ready;
    assign w_pop       = r_dir ? lcl_rd_valid & lcl_rd_ready : w_bus_pop;
    assign w_wdata     = r_dir ? r_db : lcl_wr_data;
    assign w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_cond      = r_dir ? ~w_full : (r_cnt >= CW'(THRESH) || (flush && !w_empty));
    assign w_cond_post = r_dir ? w_cnt_nxt < CW'(DEPTH)
                               : (w_cnt_nxt >= CW'(THRESH) || (flush && w_cnt_nxt != '0));
    assign w_tc_set    = w_beat_end & r_eop;
    assign w_err_set   = (w_beat_end & (r_dir ? w_full : w_empty)) |
                         ((r_state == IDLE || r_state == GAP) & ~w_strb & DACK);

    assign DREQ        = r_dreq;
    assign DB_OUT      = (r_dir || w_empty) ? 8'h00 : r_mem[r_rp];
    assign DB_OE       = ~r_dir & DACK & ~IOR_N & (r_state == XFER);
    assign lcl_rd_data = r_mem[r_rp];
    assign fifo_count  = r_cnt;
    assign tc_seen     = r_tc;
    assign err         = r_err;

    // A terminal count parks the channel in IDLE until software clears tc_seen
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: w_nxt = (cfg_en && w_cond && !r_tc) ? REQ : IDLE;
            REQ:  w_nxt = DACK ? XFER : (cfg_en ? REQ : IDLE);
            XFER: begin
                if (w_beat_end)
                    w_nxt = r_eop ? IDLE : (DEMAND != 0 && cfg_en && w_cond_post) ? XFER : GAP;
                else if (!DACK && !r_beat_lo && w_strb)
                    w_nxt = REQ;
            end
            GAP:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET_N && w_push)
            r_mem[r_wp] <= w_wdata;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_dreq    <= 1'b0;
            r_dir     <= 1'b0;
            r_beat_lo <= 1'b0;
            r_eop     <= 1'b0;
            r_db      <= 8'h00;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_tc      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_dreq    <= w_nxt == REQ || w_nxt == XFER;
            if (r_state == IDLE && w_empty)
                r_dir <= cfg_dir;
            r_beat_lo <= w_lo_smp;
            r_eop     <= w_lo_smp & (~EOP_N | r_eop);
            if (~IOW_N & DACK)
                r_db  <= DB_IN;
            if (w_push)
                r_wp  <= r_wp + 1'b1;
            if (w_pop)
                r_rp  <= r_rp + 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_tc      <= w_tc_set | (r_tc & ~clr_status);
            r_err     <= w_err_set | (r_err & ~clr_status);
        end
    end
endmodule
